// File: rtl/cc_register.sv
// rtl/cc_register.sv - Y86-64 execute-stage ALU and condition-code register
//
// Computes valE for the instruction in E and, for OPq instructions, latches
// the {SF, ZF, OF} flags into a 3-bit condition-code register that feeds the
// jXX / cmovXX condition evaluator.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   e_valid     in   1   E holds a real instruction (0 = bubble)
//   e_icode     in   4   instruction code in E (OPq = 4'h6)
//   e_ifun      in   4   function code: 0 add, 1 sub, 2 and, 3 xor
//   alu_a       in  64   ALU operand A
//   alu_b       in  64   ALU operand B
//   cc_inhibit  in   1   exception in M or W, blocks CC update
//   e_stall     in   1   E stalled, blocks CC update
//   e_valE      out 64   ALU result (combinational)
//   CF          out  3   registered flags: [0] OF, [1] ZF, [2] SF
//   set_cc      out  1   CC register loads at the next edge (combinational)

module cc_register (
   input  logic        clk,
   input  logic        rst,
   input  logic        e_valid,
   input  logic [3:0]  e_icode,
   input  logic [3:0]  e_ifun,
   input  logic [63:0] alu_a,
   input  logic [63:0] alu_b,
   input  logic        cc_inhibit,
   input  logic        e_stall,
   output logic [63:0] e_valE,
   output logic [2:0]  CF,
   output logic        set_cc
);

   localparam logic [3:0] ICODE_OPQ = 4'h6;
   localparam logic [3:0] FUN_ADD   = 4'h0;
   localparam logic [3:0] FUN_SUB   = 4'h1;
   localparam logic [3:0] FUN_AND   = 4'h2;
   localparam logic [3:0] FUN_XOR   = 4'h3;
   localparam logic [2:0] CF_RESET  = 3'b010;

   logic [3:0]  w_alu_fun;
   logic [63:0] w_val;
   logic        w_of;
   logic        w_zf;
   logic        w_sf;
   logic        w_is_opq;
   logic [2:0]  r_cf;

   assign w_is_opq  = (e_icode == ICODE_OPQ);
   // Non-OPq instructions always use the adder (address/stack arithmetic).
   assign w_alu_fun = w_is_opq ? e_ifun : FUN_ADD;

   always_comb begin
      w_val = 64'd0;
      w_of  = 1'b0;
      case (w_alu_fun)
         FUN_ADD: begin
            w_val = alu_b + alu_a;
            w_of  = (alu_a[63] == alu_b[63]) && (w_val[63] != alu_b[63]);
         end
         FUN_SUB: begin
            w_val = alu_b - alu_a;
            w_of  = (alu_a[63] != alu_b[63]) && (w_val[63] != alu_b[63]);
         end
         FUN_AND: w_val = alu_b & alu_a;
         FUN_XOR: w_val = alu_b ^ alu_a;
         default: begin
            w_val = 64'd0;
            w_of  = 1'b0;
         end
      endcase
   end

   assign w_zf   = (w_val == 64'd0);
   assign w_sf   = w_val[63];
   assign e_valE = w_val;

   // Undefined OPq functions never touch the flags.
   assign set_cc = e_valid && w_is_opq && (e_ifun <= FUN_XOR) &&
                   !cc_inhibit && !e_stall;

   // HOLD / LOAD is fully decided by set_cc each cycle; reset takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cf <= CF_RESET;
      end else if (set_cc) begin
         r_cf <= {w_sf, w_zf, w_of};
      end
   end

   assign CF = r_cf;

endmodule

// File: tb/tb_cc_register.sv
// tb/tb_cc_register.sv - self-checking bench for cc_register

module tb_cc_register;

   logic        clk = 1'b0;
   logic        rst;
   logic        e_valid;
   logic [3:0]  e_icode;
   logic [3:0]  e_ifun;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic        cc_inhibit;
   logic        e_stall;
   logic [63:0] e_valE;
   logic [2:0]  CF;
   logic        set_cc;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] m_cf;
   logic       m_known = 1'b0;

   cc_register dut (
      .clk        (clk),
      .rst        (rst),
      .e_valid    (e_valid),
      .e_icode    (e_icode),
      .e_ifun     (e_ifun),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .cc_inhibit (cc_inhibit),
      .e_stall    (e_stall),
      .e_valE     (e_valE),
      .CF         (CF),
      .set_cc     (set_cc)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] m_val(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [63:0] a, input logic [63:0] b);
      if (ic != 4'h6) return b + a;
      if (fn == 4'h0) return b + a;
      if (fn == 4'h1) return b - a;
      if (fn == 4'h2) return b & a;
      if (fn == 4'h3) return b ^ a;
      return 64'd0;
   endfunction

   // Overflow from exact signed arithmetic: the 65-bit result differs from
   // its 64-bit truncation exactly when the true result is out of range.
   function automatic logic [2:0] m_flags(input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b);
      logic signed [64:0] wide;
      logic [63:0] v;
      logic of;
      v  = m_val(4'h6, fn, a, b);
      of = 1'b0;
      if (fn == 4'h0) begin
         wide = $signed({b[63], b}) + $signed({a[63], a});
         of   = (wide[64] != wide[63]);
      end else if (fn == 4'h1) begin
         wide = $signed({b[63], b}) - $signed({a[63], a});
         of   = (wide[64] != wide[63]);
      end
      return {v[63], (v == 64'd0), of};
   endfunction

   function automatic logic m_set();
      return e_valid && (e_icode == 4'h6) && (e_ifun < 4'd4) && !cc_inhibit && !e_stall;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state update at the active edge (inputs are stable there).
   always @(posedge clk) begin
      if (rst) begin
         m_cf    = 3'b010;
         m_known = 1'b1;
      end else if (m_set()) begin
         m_cf = m_flags(e_ifun, alu_a, alu_b);
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_valE", e_valE, m_val(e_icode, e_ifun, alu_a, alu_b));
      chk("model_set_cc", {63'd0, set_cc}, {63'd0, m_set()});
      if (m_known) chk("model_CF", {61'd0, CF}, {61'd0, m_cf});
   end

   // Directed step with hand-computed literal expectations.
   task automatic step(input string nm, input logic r, input logic v,
                       input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic inh, input logic st,
                       input logic [63:0] x_val, input logic x_set, input logic [2:0] x_cf);
      rst = r; e_valid = v; e_icode = ic; e_ifun = fn;
      alu_a = a; alu_b = b; cc_inhibit = inh; e_stall = st;
      #1;
      chk({nm, "_valE"}, e_valE, x_val);
      chk({nm, "_set_cc"}, {63'd0, set_cc}, {63'd0, x_set});
      @(posedge clk); #1;
      chk({nm, "_CF"}, {61'd0, CF}, {61'd0, x_cf});
   endtask

   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   task automatic set_101();
      step("ovf_pre", 0, 1, 4'h6, 4'h0, 64'h1, MAXP, 0, 0, MINN, 1, 3'b101);
   endtask

   function automatic logic [63:0] rand_op();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return ONES;
         3: return MINN;
         4: return MAXP;
         default: return r;
      endcase
   endfunction

   initial begin
      rst = 1; e_valid = 0; e_icode = 4'h1; e_ifun = 4'h0;
      alu_a = 64'd0; alu_b = 64'd0; cc_inhibit = 0; e_stall = 0;
      @(posedge clk); #1;

      step("reset0", 1, 0, 4'h1, 4'h0, 64'd0, 64'd0, 0, 0, 64'd0, 0, 3'b010);
      step("reset1", 1, 0, 4'h1, 4'h0, 64'd0, 64'd0, 0, 0, 64'd0, 0, 3'b010);
      step("idle0",  0, 0, 4'h1, 4'h0, 64'd0, 64'd0, 0, 0, 64'd0, 0, 3'b010);
      step("idle1",  0, 0, 4'h1, 4'h0, 64'd0, 64'd0, 0, 0, 64'd0, 0, 3'b010);

      step("add_ovf",  0, 1, 4'h6, 4'h0, 64'h1, MAXP, 0, 0, MINN, 1, 3'b101);
      step("sub_zero", 0, 1, 4'h6, 4'h1, 64'h1234, 64'h1234, 0, 0, 64'd0, 1, 3'b010);
      step("sub_ovf",  0, 1, 4'h6, 4'h1, 64'h1, MINN, 0, 0, MAXP, 1, 3'b001);

      set_101();
      step("xor_zero", 0, 1, 4'h6, 4'h3, 64'hFFFF, 64'hFFFF, 0, 0, 64'd0, 1, 3'b010);
      step("and_neg",  0, 1, 4'h6, 4'h2, MINN, ONES, 0, 0, MINN, 1, 3'b100);

      set_101();
      step("inhibit",  0, 1, 4'h6, 4'h1, 64'h1234, 64'h1234, 1, 0, 64'd0, 0, 3'b101);
      set_101();
      step("stall",    0, 1, 4'h6, 4'h1, 64'h1234, 64'h1234, 0, 1, 64'd0, 0, 3'b101);
      step("unstall",  0, 1, 4'h6, 4'h1, 64'h1234, 64'h1234, 0, 0, 64'd0, 1, 3'b010);
      set_101();
      step("bubble",   0, 0, 4'h6, 4'h1, 64'h1234, 64'h1234, 0, 0, 64'd0, 0, 3'b101);
      step("bad_ifun", 0, 1, 4'h6, 4'h7, 64'h55, 64'hAA, 0, 0, 64'd0, 0, 3'b101);
      step("irmovq",   0, 1, 4'h3, 4'h0, 64'd0, 64'd0, 0, 0, 64'd0, 0, 3'b101);
      step("inh_stl",  0, 1, 4'h6, 4'h1, 64'h1234, 64'h1234, 1, 1, 64'd0, 0, 3'b101);

      step("rst_coll", 1, 1, 4'h6, 4'h0, 64'h1, MAXP, 0, 0, MINN, 1, 3'b010);
      step("post_rst", 0, 1, 4'h6, 4'h0, 64'h1, MAXP, 0, 0, MINN, 1, 3'b101);

      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         e_valid    = ($urandom_range(0, 7) != 0);
         e_icode    = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
         e_ifun     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 3));
         alu_a      = rand_op();
         alu_b      = rand_op();
         cc_inhibit = ($urandom_range(0, 7) == 0);
         e_stall    = ($urandom_range(0, 7) == 0);
         @(posedge clk); #1;
      end

      rst = 0; e_valid = 0;
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
